vend_sequencer: RTL
===================

// Module: vend_sequencer
// PURPOSE
//   Top-level transaction controller for the coin vending machine. Latches one item selection
//   and accumulates nickel/dime credit against that item's price. It then issues a single
//   dispense pulse and pays out change as a train of nickel_out pulses. Handles cancel,
//   inactivity timeout and coin rejection. Sits between the coin acceptor / keypad and the
//   dispense and coin-return actuators. Replaces per-item parallel FSMs with one shared
//   credit datapath.
// PARAMETERS
//   CREDIT_W        4      credit register width, in nickel units (must hold max price + 2)
//   TIMEOUT_CYCLES  1024   idle cycles in COLLECT before automatic refund
//   TMR_W           10     timeout counter width, clog2(TIMEOUT_CYCLES)
// PORTS
//   clock          in   1         single system clock, rising edge
//   reset          in   1         asynchronous, active-high; clears all state
//   item_number    in   4         one-hot selection; 0001/0010/0100/1000 = items 1..4
//   nickel_in      in   1         1-cycle pulse, 5c coin accepted by acceptor
//   dime_in        in   1         1-cycle pulse, 10c coin accepted by acceptor
//   cancel         in   1         level/pulse, request refund of current credit
//   dispense       out  1         1-cycle pulse, release selected item
//   nickel_out     out  1         1-cycle pulse per 5c returned
//   coin_reject    out  1         1-cycle pulse, coin arrived when not accepting; acceptor returns it
//   busy           out  1         high in any state other than IDLE
//   credit         out  CREDIT_W  current credit in nickels
// BEHAVIOUR
//   - Reset: state=IDLE; credit=0; timer=0; selected item cleared; all outputs 0.
//   - Reset mid-transaction aborts immediately. Credit is discarded with no change pulses.
//   - All outputs are registered. Coin value is nickel=1, dime=2.
//   - Simultaneous nickel_in and dime_in in one cycle adds 3.
//   - Prices in nickels: item1=3 (15c), item2=4 (20c), item3=5 (25c), item4=6 (30c).
//   - IDLE:
//       * Valid one-hot item_number latches the item and goes to COLLECT next edge.
//       * Zero or multi-hot item_number is ignored.
//       * Any coin in IDLE gives coin_reject=1 for 1 cycle. Credit is unchanged.
//   - COLLECT:
//       * item_number is ignored; the selection is locked.
//       * At each edge, credit <= credit + coin_value.
//       * If credit + coin_value >= price at that edge, go to DISPENSE with
//         credit <= credit + coin_value - price. dispense is high in the following cycle.
//       * cancel (priority below a completing coin) goes to CHANGE with credit kept.
//         With credit 0 it goes to IDLE.
//       * Timer resets on every coin. Timer reaching TIMEOUT_CYCLES-1 acts as cancel.
//   - DISPENSE:
//       * Lasts exactly 1 cycle with dispense=1.
//       * Next state is CHANGE if credit>0, else IDLE.
//   - CHANGE:
//       * Each cycle: nickel_out=1 and credit decrements by 1. Pulses are back-to-back.
//       * Go to IDLE when credit reaches 0. No cycle has nickel_out=1 with credit already 0.
//   - Coins during DISPENSE or CHANGE give coin_reject and are never credited.
//   - cancel outside COLLECT is ignored.
//   - Invariant: dispense and nickel_out are never high in the same cycle.
//   - Invariant: total nickel_out pulses = coins in - price when dispensed; = coins in when cancelled.
// STRUCTURE
//   - Package vend_pkg:
//       * state enum {IDLE, COLLECT, DISPENSE, CHANGE}
//       * item one-hot localparams ITEM1..ITEM4
//       * function price_of(item) returning nickel count
//       * coin values NICKEL_VAL=1, DIME_VAL=2
//   - One sub-module vend_timeout: counter with clear/enable, expired output.
//   - FSM, credit register and price compare stay in vend_sequencer.
// TESTING
//   1. Select 0001, nickel, dime
//      -> dispense 1 cycle after dime edge; credit 0; no nickel_out.
//   2. Select 0001, dime, dime
//      -> dispense, then exactly 1 nickel_out pulse; credit ends 0; busy drops.
//   3. Select 1000, dime, dime, then dime+nickel in the same cycle
//      -> credit 7 > 6; dispense, then 1 nickel_out.
//   4. Select 0100, nickel, dime, cancel
//      -> no dispense; 3 consecutive nickel_out pulses; IDLE.
//   5. Select 0010, one nickel, then TIMEOUT_CYCLES idle
//      -> 1 nickel_out; IDLE. Coin in IDLE -> coin_reject, credit stays 0.
//   6. Select 0011 -> ignored. Reset asserted during CHANGE -> all outputs 0 immediately, no further pulses.

Source files
------------

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types, item encodings, prices and coin values for the vending sequencer
//
// Purpose: common definitions imported by vend_sequencer and vend_timeout.
//   state_e      : transaction FSM states
//   ITEM1..ITEM4 : one-hot keypad encodings
//   NICKEL_VAL / DIME_VAL : coin values in nickel units
//   price_of()   : item price in nickels (0 for anything that is not a valid one-hot item)
//   is_item()    : true for exactly one of the four one-hot encodings
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_e;

  localparam logic [3:0] ITEM1 = 4'b0001;
  localparam logic [3:0] ITEM2 = 4'b0010;
  localparam logic [3:0] ITEM3 = 4'b0100;
  localparam logic [3:0] ITEM4 = 4'b1000;

  localparam logic [1:0] NICKEL_VAL = 2'd1;
  localparam logic [1:0] DIME_VAL   = 2'd2;

  function automatic logic [3:0] price_of(input logic [3:0] item);
    logic [3:0] p;
    case (item)
      ITEM1:   p = 4'd3;
      ITEM2:   p = 4'd4;
      ITEM3:   p = 4'd5;
      ITEM4:   p = 4'd6;
      default: p = 4'd0;
    endcase
    return p;
  endfunction

  function automatic logic is_item(input logic [3:0] item);
    return (item == ITEM1) || (item == ITEM2) || (item == ITEM3) || (item == ITEM4);
  endfunction

endpackage

// File: rtl/vend_timeout.sv
// rtl/vend_timeout.sv - inactivity counter with clear/enable and an expired flag
//
// Purpose: counts enabled cycles since the last clear; flags expiry once the count
//   reaches TIMEOUT_CYCLES-1 and holds there until cleared.
// Ports:
//   clock      in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high
//   clear_i    in   1      restart the count from zero (wins over enable)
//   enable_i   in   1      advance the count this cycle
//   expired_o  out  1      count has reached TIMEOUT_CYCLES-1 while enabled
module vend_timeout
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMR_W          = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] count_q;
  logic             at_last;

  assign at_last   = (count_q == LAST);
  assign expired_o = enable_i && at_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !at_last) begin
      count_q <= count_q + TMR_W'(1);
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - vending transaction controller: select, collect credit, dispense, pay change
//
// Purpose: latches one item, accumulates nickel/dime credit against its price, pulses
//   dispense once and returns change as back-to-back nickel_out pulses. Handles cancel,
//   inactivity timeout and rejection of coins that arrive when not collecting.
// Ports:
//   clock        in   1         system clock, rising edge
//   reset        in   1         asynchronous, active-high; clears all state
//   item_number  in   4         one-hot item select (items 1..4)
//   nickel_in    in   1         5c coin accepted pulse
//   dime_in      in   1         10c coin accepted pulse
//   cancel       in   1         refund request (only honoured while collecting)
//   dispense     out  1         1-cycle release pulse
//   nickel_out   out  1         1-cycle pulse per 5c returned
//   coin_reject  out  1         1-cycle pulse, coin arrived when not collecting
//   busy         out  1         high whenever not IDLE
//   credit       out  CREDIT_W  current credit in nickels
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int CREDIT_W       = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMR_W          = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          item_number,
  input  logic                nickel_in,
  input  logic                dime_in,
  input  logic                cancel,
  output logic                dispense,
  output logic                nickel_out,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  state_e              state_q;
  logic [3:0]          item_q;
  logic [CREDIT_W-1:0] credit_q;
  logic                dispense_q;
  logic                nickel_out_q;
  logic                coin_reject_q;
  logic                busy_q;

  logic [1:0]          coin_val_d;
  logic                coin_any_d;
  logic [CREDIT_W:0]   sum_d;
  logic [CREDIT_W:0]   price_d;
  logic                paid_d;
  logic                give_up_d;
  logic                in_collect_d;
  logic                tmr_expired;

  // One extra bit on the sum so credit + coin never wraps before the price compare.
  assign coin_val_d   = (nickel_in ? NICKEL_VAL : 2'd0) + (dime_in ? DIME_VAL : 2'd0);
  assign coin_any_d   = nickel_in | dime_in;
  assign sum_d        = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val_d);
  assign price_d      = (CREDIT_W+1)'(price_of(item_q));
  assign paid_d       = (sum_d >= price_d);
  assign in_collect_d = (state_q == COLLECT);
  // A timeout is handled exactly like a customer cancel.
  assign give_up_d    = cancel | tmr_expired;

  // Timer only runs while collecting and restarts on every coin.
  vend_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (!in_collect_d || coin_any_d),
    .enable_i  (in_collect_d),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      item_q        <= '0;
      credit_q      <= '0;
      dispense_q    <= 1'b0;
      nickel_out_q  <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      dispense_q    <= 1'b0;
      nickel_out_q  <= 1'b0;
      coin_reject_q <= 1'b0;

      case (state_q)
        IDLE: begin
          coin_reject_q <= coin_any_d;
          if (is_item(item_number)) begin
            item_q  <= item_number;
            state_q <= COLLECT;
            busy_q  <= 1'b1;
          end
        end

        COLLECT: begin
          if (paid_d) begin
            credit_q   <= CREDIT_W'(sum_d - price_d);
            state_q    <= DISPENSE;
            dispense_q <= 1'b1;
          end else if (give_up_d) begin
            // A coin landing in the same cycle as the cancel is still refunded.
            credit_q <= CREDIT_W'(sum_d);
            if (sum_d != '0) begin
              state_q      <= CHANGE;
              nickel_out_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              item_q  <= '0;
              busy_q  <= 1'b0;
            end
          end else begin
            credit_q <= CREDIT_W'(sum_d);
          end
        end

        DISPENSE: begin
          coin_reject_q <= coin_any_d;
          if (credit_q != '0) begin
            state_q      <= CHANGE;
            nickel_out_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            item_q  <= '0;
            busy_q  <= 1'b0;
          end
        end

        CHANGE: begin
          // The pulse visible this cycle pays for the nickel removed at this edge;
          // the next pulse is raised only if credit remains afterwards.
          coin_reject_q <= coin_any_d;
          if (credit_q <= CREDIT_W'(1)) begin
            credit_q <= '0;
            state_q  <= IDLE;
            item_q   <= '0;
            busy_q   <= 1'b0;
          end else begin
            credit_q     <= credit_q - CREDIT_W'(1);
            nickel_out_q <= 1'b1;
          end
        end

        default: begin
          state_q  <= IDLE;
          item_q   <= '0;
          credit_q <= '0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign dispense    = dispense_q;
  assign nickel_out  = nickel_out_q;
  assign coin_reject = coin_reject_q;
  assign busy        = busy_q;
  assign credit      = credit_q;

endmodule
